// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - alu_op codes and hazard controller state encoding
package pipe_pkg;

  localparam logic [5:0] ADD  = 6'b000001;
  localparam logic [5:0] SUB  = 6'b000010;
  localparam logic [5:0] SLL  = 6'b000011;
  localparam logic [5:0] XOR  = 6'b000100;
  localparam logic [5:0] SRL  = 6'b000101;
  localparam logic [5:0] OR   = 6'b000110;
  localparam logic [5:0] AND  = 6'b000111;
  localparam logic [5:0] LW   = 6'b001000;
  localparam logic [5:0] ADDI = 6'b001001;
  localparam logic [5:0] SW   = 6'b001010;
  localparam logic [5:0] BEQ  = 6'b001011;
  localparam logic [5:0] BLT  = 6'b001100;
  localparam logic [5:0] BGE  = 6'b001101;
  localparam logic [5:0] JAL  = 6'b001110;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    FREEZE = 2'd1,
    HALT   = 2'd2
  } pipe_state_e;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with synchronous clear
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - pipeline hazard, redirect and memory-freeze controller
module pipe_ctrl
  import pipe_pkg::*;
#(
  parameter int CNT_W      = 16,
  parameter int WD_TIMEOUT = 255,
  parameter int WD_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_rs1_used,
  input  logic             id_rs2_used,
  input  logic [5:0]       ex_alu_op,
  input  logic [4:0]       ex_rd,
  input  logic             ex_flush,
  input  logic [31:0]      ex_new_inst_addr,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_stall,
  output logic             if_id_stall,
  output logic             if_id_flush,
  output logic             id_ex_bubble,
  output logic             ex_mem_stall,
  output logic             pc_redirect,
  output logic [31:0]      pc_redirect_addr,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(WD_TIMEOUT);

  pipe_state_e     state_q, state_d;
  logic [WD_W-1:0] wd_q, wd_d;
  logic [WD_W-1:0] wd_inc;
  logic [31:0]     addr_q, addr_d;
  logic            freeze_cond;
  logic            lu_hazard;

  assign freeze_cond = mem_req & ~mem_ready;
  assign wd_inc      = wd_q + 1'b1;

  // An unknown alu_op makes the == compare non-true, so the hazard branch is not taken.
  assign lu_hazard = id_valid & (ex_alu_op == LW) & (ex_rd != 5'd0)
                   & ((id_rs1_used & (id_rs1 == ex_rd)) | (id_rs2_used & (id_rs2 == ex_rd)));

  always_comb begin
    state_d      = state_q;
    wd_d         = wd_q;
    addr_d       = addr_q;
    pc_stall     = 1'b0;
    if_id_stall  = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    ex_mem_stall = 1'b0;
    pc_redirect  = 1'b0;
    if (!rst) begin
      unique case (state_q)
        RUN: begin
          if (freeze_cond) begin
            pc_stall     = 1'b1;
            if_id_stall  = 1'b1;
            ex_mem_stall = 1'b1;
            wd_d         = WD_W'(1);
            state_d      = (WD_LIMIT <= WD_W'(1)) ? HALT : FREEZE;
          end else if (ex_flush) begin
            pc_redirect  = 1'b1;
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
            addr_d       = ex_new_inst_addr;
          end else if (lu_hazard) begin
            pc_stall     = 1'b1;
            if_id_stall  = 1'b1;
            id_ex_bubble = 1'b1;
          end
        end
        FREEZE: begin
          // A flush raised while EX is held waits for the first RUN cycle.
          if (freeze_cond) begin
            pc_stall     = 1'b1;
            if_id_stall  = 1'b1;
            ex_mem_stall = 1'b1;
            wd_d         = wd_inc;
            if (wd_inc >= WD_LIMIT) begin
              state_d = HALT;
            end
          end else begin
            wd_d    = '0;
            state_d = RUN;
          end
        end
        HALT: begin
          pc_stall     = 1'b1;
          if_id_stall  = 1'b1;
          ex_mem_stall = 1'b1;
        end
        default: begin
          state_d = RUN;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      wd_q    <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      wd_q    <= wd_d;
      addr_q  <= addr_d;
    end
  end

  assign halted           = (state_q == HALT) & ~rst;
  assign pc_redirect_addr = pc_redirect ? ex_new_inst_addr : addr_q;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr_i (1'b0),
    .inc_i (pc_stall),
    .cnt_o (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr_i (1'b0),
    .inc_i (pc_redirect),
    .cnt_o (flush_cnt)
  );

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - randomized and directed bench for pipe_ctrl
module tb_pipe_ctrl;
  import pipe_pkg::*;

  localparam int CNT_W = 4;
  localparam int WD_TO = 4;
  localparam int WD_W  = 8;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             id_valid, id_rs1_used, id_rs2_used, ex_flush, mem_req, mem_ready;
  logic [4:0]       id_rs1, id_rs2, ex_rd;
  logic [5:0]       ex_alu_op;
  logic [31:0]      ex_new_inst_addr;
  logic             pc_stall, if_id_stall, if_id_flush, id_ex_bubble, ex_mem_stall;
  logic             pc_redirect, halted;
  logic [31:0]      pc_redirect_addr;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  int vectors     = 0;
  int miscompares = 0;

  // Reference state: consecutive frozen cycles, sticky halt, last target, event tallies.
  int          m_frz_len = 0;
  bit          m_halt    = 1'b0;
  logic [31:0] m_addr    = '0;
  int          m_stall   = 0;
  int          m_flush   = 0;

  always #5 clk = ~clk;

  pipe_ctrl #(.CNT_W(CNT_W), .WD_TIMEOUT(WD_TO), .WD_W(WD_W)) dut (
    .clk              (clk),
    .rst              (rst),
    .id_valid         (id_valid),
    .id_rs1           (id_rs1),
    .id_rs2           (id_rs2),
    .id_rs1_used      (id_rs1_used),
    .id_rs2_used      (id_rs2_used),
    .ex_alu_op        (ex_alu_op),
    .ex_rd            (ex_rd),
    .ex_flush         (ex_flush),
    .ex_new_inst_addr (ex_new_inst_addr),
    .mem_req          (mem_req),
    .mem_ready        (mem_ready),
    .pc_stall         (pc_stall),
    .if_id_stall      (if_id_stall),
    .if_id_flush      (if_id_flush),
    .id_ex_bubble     (id_ex_bubble),
    .ex_mem_stall     (ex_mem_stall),
    .pc_redirect      (pc_redirect),
    .pc_redirect_addr (pc_redirect_addr),
    .halted           (halted),
    .stall_cnt        (stall_cnt),
    .flush_cnt        (flush_cnt)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%h, expected 0x%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle();
    id_valid = 1'b0; id_rs1 = '0; id_rs2 = '0; id_rs1_used = 1'b0; id_rs2_used = 1'b0;
    ex_alu_op = ADD; ex_rd = '0; ex_flush = 1'b0; ex_new_inst_addr = '0;
    mem_req = 1'b0; mem_ready = 1'b0;
  endtask

  task automatic set_lu(input logic [4:0] rd, input logic [4:0] rs2);
    idle();
    id_valid = 1'b1; ex_alu_op = LW; ex_rd = rd; id_rs2 = rs2; id_rs2_used = 1'b1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin : compare
    logic fc, hz;
    logic e_ps, e_is, e_if, e_bb, e_ms, e_rd, e_h;
    forever begin
      @(negedge clk);
      #2;
      {e_ps, e_is, e_if, e_bb, e_ms, e_rd, e_h} = '0;
      if (rst) begin
        m_frz_len = 0; m_halt = 1'b0; m_addr = '0; m_stall = 0; m_flush = 0;
      end else begin
        fc = mem_req && !mem_ready;
        hz = id_valid && (ex_alu_op == LW) && (ex_rd != 5'd0) &&
             ((id_rs1_used && (id_rs1 == ex_rd)) || (id_rs2_used && (id_rs2 == ex_rd)));
        if (m_halt) begin
          {e_ps, e_is, e_ms, e_h} = 4'b1111;
        end else if (fc) begin
          {e_ps, e_is, e_ms} = 3'b111;
          m_frz_len++;
          if (m_frz_len >= WD_TO) m_halt = 1'b1;
        end else if (m_frz_len != 0) begin
          m_frz_len = 0;
        end else if (ex_flush) begin
          {e_rd, e_if, e_bb} = 3'b111;
          m_addr = ex_new_inst_addr;
        end else if (hz) begin
          {e_ps, e_is, e_bb} = 3'b111;
        end
      end
      chk("ctl", 32'({pc_stall, if_id_stall, if_id_flush, id_ex_bubble, ex_mem_stall, pc_redirect, halted}),
                 32'({e_ps, e_is, e_if, e_bb, e_ms, e_rd, e_h}));
      chk("redirect_addr", pc_redirect_addr, m_addr);
      chk("stall_cnt", 32'(stall_cnt), 32'(m_stall));
      chk("flush_cnt", 32'(flush_cnt), 32'(m_flush));
      if (!rst) begin
        if (e_ps && m_stall < CMAX) m_stall++;
        if (e_rd && m_flush < CMAX) m_flush++;
      end
    end
  end

  initial begin : stimulus
    idle();
    do_reset();
    #3;
    chk("reset_stall_cnt", 32'(stall_cnt), 32'd0);
    chk("reset_flush_cnt", 32'(flush_cnt), 32'd0);
    chk("reset_halted", 32'(halted), 32'd0);
    chk("reset_addr", pc_redirect_addr, 32'd0);

    @(negedge clk); set_lu(5'd5, 5'd5);
    #3 chk("lu_ctl", 32'({pc_stall, if_id_stall, id_ex_bubble, ex_mem_stall}), 32'b1110);
    @(negedge clk); idle();
    #3 chk("lu_once", 32'(pc_stall), 32'd0);
    chk("lu_stall_cnt", 32'(stall_cnt), 32'd1);
    @(negedge clk); set_lu(5'd0, 5'd0);
    #3 chk("lu_rd0", 32'(pc_stall), 32'd0);

    do_reset();
    @(negedge clk); set_lu(5'd5, 5'd5); ex_flush = 1'b1; ex_new_inst_addr = 32'h0000_0040;
    #3 chk("mp_ctl", 32'({pc_redirect, if_id_flush, id_ex_bubble, pc_stall}), 32'b1110);
    chk("mp_addr", pc_redirect_addr, 32'h40);
    @(negedge clk); idle();
    #3 chk("mp_flush_cnt", 32'(flush_cnt), 32'd1);
    chk("mp_addr_hold", pc_redirect_addr, 32'h40);

    do_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); idle(); mem_req = 1'b1; ex_flush = 1'b1; ex_new_inst_addr = 32'h80;
      #3 chk("frz_stalls", 32'({pc_stall, if_id_stall, ex_mem_stall, pc_redirect}), 32'b1110);
    end
    @(negedge clk); mem_ready = 1'b1;
    #3 chk("frz_exit", 32'({pc_stall, ex_mem_stall, pc_redirect}), 32'd0);
    @(negedge clk); mem_req = 1'b0; mem_ready = 1'b0;
    #3 chk("frz_deferred_redirect", 32'(pc_redirect), 32'd1);
    chk("frz_deferred_addr", pc_redirect_addr, 32'h80);
    chk("frz_stall_cnt", 32'(stall_cnt), 32'd3);

    do_reset();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); idle(); mem_req = 1'b1;
      #3 chk("wd_not_yet", 32'(halted), 32'd0);
    end
    @(negedge clk); mem_ready = 1'b1; ex_flush = 1'b1;
    #3 chk("wd_halted", 32'({halted, pc_stall, ex_mem_stall, pc_redirect}), 32'b1110);
    @(negedge clk); idle();
    #3 chk("wd_sticky", 32'(halted), 32'd1);
    do_reset();
    #3 chk("wd_cleared", 32'({halted, stall_cnt, flush_cnt}), 32'd0);

    @(negedge clk); idle(); mem_req = 1'b1;
    @(negedge clk);
    #3 rst = 1'b1;
    #1 chk("async_rst", 32'({pc_stall, if_id_stall, ex_mem_stall, halted, stall_cnt}), 32'd0);
    idle();
    @(negedge clk);
    @(negedge clk); rst = 1'b0;

    @(negedge clk); set_lu(5'd7, 5'd7);
    repeat (20) @(negedge clk);
    #3 chk("sat_stall_cnt", 32'(stall_cnt), 32'd15);
    @(negedge clk); set_lu(5'd5, 5'd5); ex_alu_op = 6'bxxxxxx;
    #3 chk("x_no_hazard", 32'(pc_stall), 32'd0);

    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      rst              = ($urandom_range(0, 59) == 0);
      id_valid         = ($urandom_range(0, 3) != 0);
      id_rs1           = 5'($urandom_range(0, 3));
      id_rs2           = 5'($urandom_range(0, 3));
      id_rs1_used      = 1'($urandom_range(0, 1));
      id_rs2_used      = 1'($urandom_range(0, 1));
      ex_alu_op        = ($urandom_range(0, 2) == 0) ? LW : 6'($urandom_range(0, 14));
      ex_rd            = 5'($urandom_range(0, 3));
      ex_flush         = ($urandom_range(0, 5) == 0);
      ex_new_inst_addr = $urandom;
      mem_req          = 1'($urandom_range(0, 1));
      mem_ready        = ($urandom_range(0, 2) == 0);
    end
    @(negedge clk); idle(); rst = 1'b0;
    @(negedge clk);
    #3;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
